// File: rtl/rxuart_fifo.sv
// Receive FIFO behind the UART receiver: queues {break, frame_err, parity_err, data}
// in a first-word-fall-through buffer with fill, half-full and sticky overflow status.
module rxuart_fifo #(
  parameter int LGFLEN = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr,
  input  logic [7:0]        i_data,
  input  logic              i_break,
  input  logic              i_parity_err,
  input  logic              i_frame_err,
  input  logic              i_flush,
  input  logic              i_rd,
  input  logic              i_clr_ovfl,
  output logic              o_empty_n,
  output logic [10:0]       o_rdata,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_half,
  output logic              o_overflow
);

  localparam logic [LGFLEN:0] DEPTH = (LGFLEN+1)'(1) << LGFLEN;
  localparam logic [LGFLEN:0] HALF  = (LGFLEN+1)'(1) << (LGFLEN-1);

  logic [10:0]       mem [0:(1<<LGFLEN)-1];
  logic [LGFLEN-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic              pend_par, pend_frm, brk_d, brk_pend;
  logic              brk_rise, brk_push, push, pop, push_ok, dropped;
  logic [10:0]       wdata;
  logic [LGFLEN:0]   fill_nxt;

  always_comb begin
    brk_rise = i_break & ~brk_d;
    // A break edge colliding with a data write waits in brk_pend for a free cycle
    brk_push = ~i_wr & (brk_rise | brk_pend);
    push     = i_wr | brk_push;
    pop      = i_rd & o_empty_n;
    push_ok  = push & ((o_fill != DEPTH) | pop);
    dropped  = push & ~push_ok;
    wdata    = {brk_push, pend_frm | i_frame_err, pend_par | i_parity_err,
                i_wr ? i_data : 8'h00};
    rd_nxt   = rd_ptr + 1'b1;
    fill_nxt = o_fill;
    if (push_ok & ~pop)      fill_nxt = o_fill + 1'b1;
    else if (pop & ~push_ok) fill_nxt = o_fill - 1'b1;
  end

  always_ff @(posedge i_clk)
    if (push_ok & ~i_flush) mem[wr_ptr] <= wdata;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_fill     <= '0;
      o_half     <= 1'b0;
      o_empty_n  <= 1'b0;
      o_rdata    <= '0;
      o_overflow <= 1'b0;
      pend_par   <= 1'b0;
      pend_frm   <= 1'b0;
      brk_d      <= 1'b0;
      brk_pend   <= 1'b0;
    end else begin
      brk_d <= i_break;
      if (dropped & ~i_flush) o_overflow <= 1'b1;
      else if (i_clr_ovfl)    o_overflow <= 1'b0;

      if (i_flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        o_fill    <= '0;
        o_half    <= 1'b0;
        o_empty_n <= 1'b0;
        pend_par  <= 1'b0;
        pend_frm  <= 1'b0;
        brk_pend  <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_nxt;
        o_fill <= fill_nxt;
        o_half <= (fill_nxt >= HALF);

        if (push) begin
          pend_par <= 1'b0;
          pend_frm <= 1'b0;
        end else begin
          pend_par <= pend_par | i_parity_err;
          pend_frm <= pend_frm | i_frame_err;
        end

        if (i_wr & brk_rise) brk_pend <= 1'b1;
        else if (brk_push)   brk_pend <= 1'b0;

        // Head register: prefetch on pop (forwarding a same-cycle write), else load when idle-empty
        if (pop) begin
          o_rdata   <= (push_ok && wr_ptr == rd_nxt) ? wdata : mem[rd_nxt];
          o_empty_n <= (o_fill > (LGFLEN+1)'(1)) | push_ok;
        end else if (!o_empty_n && o_fill != '0) begin
          o_rdata   <= mem[rd_ptr];
          o_empty_n <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rxuart_fifo.sv
// Directed bench for rxuart_fifo: vector table on a depth-16 instance plus hand sequences
// for errors, break, overflow (depth-4 instance), flush and asynchronous reset.
module tb_rxuart_fifo;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_wr = 1'b0, i_break = 1'b0, i_parity_err = 1'b0, i_frame_err = 1'b0;
  logic        i_flush = 1'b0, i_rd = 1'b0, i_clr_ovfl = 1'b0;
  logic [7:0]  i_data = 8'h00;

  logic        a_empty_n, a_half, a_ovfl;
  logic [10:0] a_rdata;
  logic [4:0]  a_fill;
  logic        b_empty_n, b_half, b_ovfl;
  logic [10:0] b_rdata;
  logic [2:0]  b_fill;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  rxuart_fifo #(.LGFLEN(4)) dut_a (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_wr(i_wr), .i_data(i_data),
    .i_break(i_break), .i_parity_err(i_parity_err), .i_frame_err(i_frame_err),
    .i_flush(i_flush), .i_rd(i_rd), .i_clr_ovfl(i_clr_ovfl),
    .o_empty_n(a_empty_n), .o_rdata(a_rdata), .o_fill(a_fill),
    .o_half(a_half), .o_overflow(a_ovfl));

  rxuart_fifo #(.LGFLEN(2)) dut_b (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_wr(i_wr), .i_data(i_data),
    .i_break(i_break), .i_parity_err(i_parity_err), .i_frame_err(i_frame_err),
    .i_flush(i_flush), .i_rd(i_rd), .i_clr_ovfl(i_clr_ovfl),
    .o_empty_n(b_empty_n), .o_rdata(b_rdata), .o_fill(b_fill),
    .o_half(b_half), .o_overflow(b_ovfl));

  typedef struct {
    logic        wr;
    logic [7:0]  data;
    logic        rd;
    logic        flush;
    logic        en;
    logic [10:0] rdata;
    logic [4:0]  fill;
    logic        half;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic wr, logic [7:0] d, logic rd, logic fl,
                              logic en, logic [10:0] rdata, int fill, logic half);
    vec_t v;
    v.wr = wr; v.data = d; v.rd = rd; v.flush = fl;
    v.en = en; v.rdata = rdata; v.fill = 5'(fill); v.half = half;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply strobes for one clock edge, then release them and settle past the edge
  task automatic cyc(logic wr, logic [7:0] d, logic rd, logic fl, logic clr);
    i_wr = wr; i_data = d; i_rd = rd; i_flush = fl; i_clr_ovfl = clr;
    @(posedge i_clk);
    #1;
    i_wr = 1'b0; i_data = 8'h00; i_rd = 1'b0; i_flush = 1'b0; i_clr_ovfl = 1'b0;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(0, 8'h00, 0, 0, 0);
  endtask

  initial begin
    // basic order, rd-while-empty
    tbl.push_back(mk(1, 8'h41, 0, 0, 0, 11'h000, 1, 0));
    tbl.push_back(mk(1, 8'h42, 0, 0, 1, 11'h041, 2, 0));
    tbl.push_back(mk(1, 8'h43, 0, 0, 1, 11'h041, 3, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 11'h042, 2, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 11'h043, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 11'h000, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 11'h000, 0, 0));
    // half flag
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 8'(8'h80 + i), 0, 0, i >= 1, 11'h080, i + 1, i == 7));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 11'h081, 7, 0));
    tbl.push_back(mk(1, 8'h88, 1, 0, 1, 11'h082, 7, 0));
    // flush beats a same-cycle write
    tbl.push_back(mk(1, 8'h99, 0, 1, 0, 11'h000, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 11'h000, 0, 0));
    // read-during-write at fill 1
    tbl.push_back(mk(1, 8'h10, 0, 0, 0, 11'h000, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 11'h010, 1, 0));
    tbl.push_back(mk(1, 8'h11, 1, 0, 1, 11'h011, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 11'h000, 0, 0));

    // reset state
    #12;
    chk("rst_a_empty_n", 16'(a_empty_n), 16'h0);
    chk("rst_a_rdata",   16'(a_rdata),   16'h0);
    chk("rst_a_fill",    16'(a_fill),    16'h0);
    chk("rst_a_half",    16'(a_half),    16'h0);
    chk("rst_b_ovfl",    16'(b_ovfl),    16'h0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;

    foreach (tbl[i]) begin
      cyc(tbl[i].wr, tbl[i].data, tbl[i].rd, tbl[i].flush, 1'b0);
      chk($sformatf("vec%0d_empty_n", i), 16'(a_empty_n), 16'(tbl[i].en));
      chk($sformatf("vec%0d_fill", i),    16'(a_fill),    16'(tbl[i].fill));
      chk($sformatf("vec%0d_half", i),    16'(a_half),    16'(tbl[i].half));
      if (tbl[i].en) chk($sformatf("vec%0d_rdata", i), 16'(a_rdata), 16'(tbl[i].rdata));
    end

    // error tagging: pending frame error lands on the next push only
    cyc(0, 8'h00, 0, 1, 0);
    i_frame_err = 1'b1;
    idle(1);
    i_frame_err = 1'b0;
    idle(5);
    cyc(1, 8'h55, 0, 0, 0);
    cyc(1, 8'h66, 0, 0, 0);
    chk("err_head", 16'(a_rdata), 16'h255);
    chk("err_fill", 16'(a_fill),  16'd2);
    cyc(0, 8'h00, 1, 0, 0);
    chk("err_cleared", 16'(a_rdata), 16'h066);
    cyc(0, 8'h00, 1, 0, 0);
    chk("err_empty", 16'(a_empty_n), 16'h0);

    // held break yields a single entry
    i_break = 1'b1;
    idle(20);
    chk("brk_fill",  16'(a_fill),  16'd1);
    chk("brk_entry", 16'(a_rdata), 16'h400);
    i_break = 1'b0;
    idle(2);
    chk("brk_fill_after", 16'(a_fill), 16'd1);
    cyc(0, 8'h00, 1, 0, 0);
    chk("brk_popped", 16'(a_fill), 16'd0);

    // break rise colliding with a data write
    i_break = 1'b1;
    cyc(1, 8'h12, 0, 0, 0);
    chk("brkw_fill1", 16'(a_fill), 16'd1);
    idle(1);
    chk("brkw_fill2", 16'(a_fill),  16'd2);
    chk("brkw_data",  16'(a_rdata), 16'h012);
    cyc(0, 8'h00, 1, 0, 0);
    chk("brkw_brk", 16'(a_rdata), 16'h400);
    i_break = 1'b0;
    cyc(0, 8'h00, 1, 0, 0);
    chk("brkw_empty", 16'(a_empty_n), 16'h0);

    // overflow on the depth-4 instance
    cyc(0, 8'h00, 0, 1, 1);
    chk("ov_clear0", 16'(b_ovfl), 16'h0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 8'(i), 0, 0, 0);
      if (i == 4) chk("ov_no_ovfl4", 16'(b_ovfl), 16'h0);
    end
    chk("ov_fill",  16'(b_fill),  16'd4);
    chk("ov_set",   16'(b_ovfl),  16'h1);
    chk("ov_head",  16'(b_rdata), 16'h001);
    cyc(0, 8'h00, 0, 0, 1);
    chk("ov_clr", 16'(b_ovfl), 16'h0);
    cyc(1, 8'h07, 0, 0, 1);
    chk("ov_set_wins", 16'(b_ovfl), 16'h1);
    chk("ov_fill_full", 16'(b_fill), 16'd4);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(1, 8'h06, 1, 0, 0);
    chk("ov_pp_ovfl",  16'(b_ovfl),  16'h0);
    chk("ov_pp_fill",  16'(b_fill),  16'd4);
    chk("ov_pp_head",  16'(b_rdata), 16'h002);
    cyc(0, 8'h00, 1, 0, 0);
    chk("ov_pop3", 16'(b_rdata), 16'h003);
    cyc(0, 8'h00, 1, 0, 0);
    chk("ov_pop4", 16'(b_rdata), 16'h004);
    cyc(0, 8'h00, 1, 0, 0);
    chk("ov_pop6", 16'(b_rdata), 16'h006);
    cyc(0, 8'h00, 1, 0, 0);
    chk("ov_empty", 16'(b_empty_n), 16'h0);
    chk("ov_fill0", 16'(b_fill),    16'd0);

    // flush with a write in the same cycle
    cyc(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h20 + i), 0, 0, 0);
    chk("fl_fill3", 16'(a_fill), 16'd3);
    cyc(1, 8'h23, 0, 1, 0);
    chk("fl_fill", 16'(a_fill),    16'd0);
    chk("fl_en",   16'(a_empty_n), 16'h0);
    idle(1);
    chk("fl_fill_idle", 16'(a_fill),    16'd0);
    chk("fl_en_idle",   16'(a_empty_n), 16'h0);

    // asynchronous reset in the middle of a burst
    for (int i = 0; i < 9; i++) cyc(1, 8'(8'h30 + i), 0, 0, 0);
    chk("ar_pre_half", 16'(a_half), 16'h1);
    chk("ar_pre_ovfl", 16'(b_ovfl), 16'h1);
    i_wr = 1'b1; i_data = 8'h3f;
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("ar_empty_n", 16'(a_empty_n), 16'h0);
    chk("ar_rdata",   16'(a_rdata),   16'h0);
    chk("ar_fill",    16'(a_fill),    16'h0);
    chk("ar_half",    16'(a_half),    16'h0);
    chk("ar_ovfl",    16'(b_ovfl),    16'h0);
    chk("ar_b_fill",  16'(b_fill),    16'h0);
    i_wr = 1'b0; i_data = 8'h00;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    idle(1);
    chk("ar_after_fill", 16'(a_fill), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
